stream_argmax_one_hot: RTL and testbench

- Sequential successor to the combinational FP16 argmax/one-hot encoder at the DNN output layer.
- Accepts one FP16 logit per cycle over a valid/ready stream, keeps a running maximum, and emits a one-hot class vector, the winning index and the max value after N elements.
- Sits between the last pipelined dense layer and the result register/host interface.
- Removes the N-wide comparator tree, so N scales to hundreds of classes.

---
 rtl/argmax_pkg.sv | 34 +++
 rtl/fp16_gt.sv | 32 +++
 rtl/stream_argmax_one_hot.sv | 107 ++++++++++
 tb/tb_stream_argmax_one_hot.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared FP16 argmax types, constants and helpers.
// Optional build macro: ARGMAX_NAN_SKIP_EN (consumed by fp16_gt).
package argmax_pkg;

    localparam int unsigned FP16_W = 16;

    typedef logic [FP16_W-1:0] fp16_t;

    localparam fp16_t      FP16_POS_ZERO = 16'h0000;
    localparam fp16_t      FP16_NEG_ZERO = 16'h8000;
    localparam logic [4:0] FP16_EXP_MAX  = 5'h1F;

    typedef enum logic {ACCUM, HOLD} argmax_state_t;

    // NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic is_nan(input fp16_t x);
        return (x[14:10] == FP16_EXP_MAX) && (x[9:0] != 10'h000);
    endfunction

    // Map sign-magnitude bits onto an unsigned key whose ordering matches
    // the FP16 compare rules; both zeros share one key so they tie.
    function automatic logic [FP16_W-1:0] fp16_order_key(input fp16_t x);
        logic [FP16_W-1:0] key;
        if ((x == FP16_POS_ZERO) || (x == FP16_NEG_ZERO)) begin
            key = 16'h8000;
        end else if (!x[15]) begin
            key = {1'b1, x[14:0]};
        end else begin
            key = {1'b0, ~x[14:0]};
        end
        return key;
    endfunction

endpackage

// File: rtl/fp16_gt.sv
// Combinational FP16 strict greater-than (a > b), bit-ordering only.
// Optional build macro: ARGMAX_NAN_SKIP_EN makes NaN lose to everything.
module fp16_gt
    import argmax_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        a_gt_b
);

    logic [15:0] a_key;
    logic [15:0] b_key;

    // Compare order keys, optionally forcing NaN to the bottom.
    always_comb begin
        a_gt_b = 1'b0;
        a_key  = fp16_order_key(a);
        b_key  = fp16_order_key(b);
`ifdef ARGMAX_NAN_SKIP_EN
        if (is_nan(a)) begin
            a_gt_b = 1'b0;
        end else if (is_nan(b)) begin
            a_gt_b = 1'b1;
        end else begin
            a_gt_b = (a_key > b_key);
        end
`else
        a_gt_b = (a_key > b_key);
`endif
    end

endmodule

// File: rtl/stream_argmax_one_hot.sv
// Streaming FP16 argmax: one logit per cycle in, one-hot/index/max out per
// N-element vector. Optional build macro: ARGMAX_NAN_SKIP_EN (see fp16_gt).
module stream_argmax_one_hot
    import argmax_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_onehot,
    output logic [IDX_W-1:0] out_index,
    output logic [15:0]      out_max
);

    argmax_state_t    state_q;
    logic [IDX_W-1:0] count_q;
    fp16_t            best_q;
    logic [IDX_W-1:0] best_idx_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [N-1:0]     out_onehot_q;
    logic [IDX_W-1:0] out_index_q;
    fp16_t            out_max_q;

    logic             accept_c;
    logic             last_c;
    logic             new_gt_c;
    logic             take_c;
    fp16_t            best_d;
    logic [IDX_W-1:0] best_idx_d;
    logic [N-1:0]     onehot_d;

    fp16_gt u_gt (
        .a      (in_data),
        .b      (best_q),
        .a_gt_b (new_gt_c)
    );

    // Running winner including the element offered this cycle.
    always_comb begin
        accept_c   = in_valid && in_ready_q;
        last_c     = (count_q == IDX_W'(N - 1));
        take_c     = (count_q == '0) || new_gt_c;
        best_d     = take_c ? in_data : best_q;
        best_idx_d = take_c ? count_q : best_idx_q;
        onehot_d   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            onehot_d[i] = (best_idx_d == IDX_W'(i));
        end
    end

    // Accumulate / hold FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            count_q      <= '0;
            best_q       <= FP16_POS_ZERO;
            best_idx_q   <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_onehot_q <= '0;
            out_index_q  <= '0;
            out_max_q    <= FP16_POS_ZERO;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept_c) begin
                        if (last_c) begin
                            state_q      <= HOLD;
                            count_q      <= '0;
                            in_ready_q   <= 1'b0;
                            out_valid_q  <= 1'b1;
                            out_onehot_q <= onehot_d;
                            out_index_q  <= best_idx_d;
                            out_max_q    <= best_d;
                        end else begin
                            count_q      <= count_q + IDX_W'(1);
                        end
                        best_q     <= best_d;
                        best_idx_q <= best_idx_d;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q      <= ACCUM;
                        in_ready_q   <= 1'b1;
                        out_valid_q  <= 1'b0;
                        out_onehot_q <= '0;
                    end
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_index  = out_index_q;
    assign out_max    = out_max_q;

endmodule

// File: tb/tb_stream_argmax_one_hot.sv
// Scoreboard bench for stream_argmax_one_hot (N=4).
module tb_stream_argmax_one_hot;

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = 2;
    localparam int          TMO   = 200;

    typedef logic [15:0] vec_t [N];
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [15:0]      mx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_onehot;
    logic [IDX_W-1:0] out_index;
    logic [15:0]      out_max;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    stream_argmax_one_hot #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_index  (out_index),
        .out_max    (out_max)
    );

    always #5 clk = ~clk;

    // Reference compare written directly from the sign/magnitude rules.
    function automatic bit m_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 0);
    endfunction

    function automatic bit m_gt(input logic [15:0] a, input logic [15:0] b);
        bit az, bz, sa, sb;
`ifdef ARGMAX_NAN_SKIP_EN
        if (m_nan(a)) return 1'b0;
        if (m_nan(b)) return 1'b1;
`endif
        az = (a[14:0] == 0);
        bz = (b[14:0] == 0);
        if (az && bz) return 1'b0;
        sa = az ? 1'b0 : a[15];
        sb = bz ? 1'b0 : b[15];
        if (sa != sb) return sb;
        if (!sa) return a[14:0] > b[14:0];
        return a[14:0] < b[14:0];
    endfunction

    function automatic exp_t model(input vec_t v);
        exp_t e;
        e.idx = '0;
        e.mx  = v[0];
        for (int i = 1; i < N; i++) begin
            if (m_gt(v[i], e.mx)) begin
                e.idx = IDX_W'(i);
                e.mx  = v[i];
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(input int idx, input logic [15:0] mx);
        exp_t e;
        e.idx = IDX_W'(idx);
        e.mx  = mx;
        return e;
    endfunction

    // Offer one element (called at a negedge), return on the next negedge.
    task automatic send_elem(input logic [15:0] d);
        int t = 0;
        while (in_ready !== 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic send_vec(input vec_t v, input int gap);
        for (int i = 0; i < N; i++) begin
            send_elem(v[i]);
            if (gap > 0 && i < N - 1) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait for a result, check it against the scoreboard, hold, handshake.
    task automatic collect(input int hold_cycles);
        int   t = 0;
        exp_t e;
        logic [N-1:0] exp_oh;
        while (out_valid !== 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= TMO) begin
            errors++;
            $display("FAIL out_valid_timeout out_valid=%b required=1", out_valid);
        end
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty size=0 required>0");
            return;
        end
        e      = sb_q.pop_front();
        exp_oh = N'(1) << e.idx;
        checks++;
        if (out_index !== e.idx) begin
            errors++;
            $display("FAIL out_index got=%0d exp=%0d", out_index, e.idx);
        end
        checks++;
        if (out_onehot !== exp_oh) begin
            errors++;
            $display("FAIL out_onehot got=%b exp=%b", out_onehot, exp_oh);
        end
        checks++;
        if (out_max !== e.mx) begin
            errors++;
            $display("FAIL out_max got=%h exp=%h", out_max, e.mx);
        end
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_index !== e.idx ||
                out_onehot !== exp_oh || out_max !== e.mx) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d valid=%b ready=%b idx=%0d oh=%b max=%h exp idx=%0d oh=%b max=%h",
                         i, out_valid, in_ready, out_index, out_onehot, out_max, e.idx, exp_oh, e.mx);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_onehot !== '0) begin
            errors++;
            $display("FAIL post_handshake valid=%b ready=%b oh=%b exp 0/1/0", out_valid, in_ready, out_onehot);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_onehot !== '0 ||
            out_index !== '0 || out_max !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state ready=%b valid=%b oh=%b idx=%0d max=%h exp 1/0/0/0/0000",
                     in_ready, out_valid, out_onehot, out_index, out_max);
        end
    endtask

    task automatic test_basic();
        vec_t v = '{16'h3C00, 16'h4000, 16'hBC00, 16'h3800};
        sb_q.push_back(mk(1, 16'h4000));
        send_vec(v, 0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency out_valid=%b exp=1", out_valid);
        end
        collect(0);
    endtask

    task automatic test_ties();
        vec_t a = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
        vec_t b = '{16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00};
        sb_q.push_back(mk(0, 16'h3C00));
        send_vec(a, 0);
        collect(0);
        sb_q.push_back(mk(0, 16'hBC00));
        send_vec(b, 0);
        collect(0);
    endtask

    task automatic test_zero_sign();
        vec_t a = '{16'h0000, 16'h8000, 16'h0000, 16'h8000};
        vec_t b = '{16'hC000, 16'h4000, 16'h3C00, 16'h3800};
        sb_q.push_back(mk(0, 16'h0000));
        send_vec(a, 0);
        collect(1);
        sb_q.push_back(mk(1, 16'h4000));
        send_vec(b, 0);
        collect(0);
    endtask

    task automatic test_bubbles_backpressure();
        vec_t a = '{16'h3C00, 16'h3C01, 16'h3C02, 16'h3C03};
        vec_t b = '{16'h8001, 16'h0001, 16'hFC00, 16'h7C00};
        sb_q.push_back(mk(3, 16'h3C03));
        send_vec(a, 2);
        collect(5);
        // in_ready is already 1 here, so the next vector starts immediately.
        sb_q.push_back(mk(3, 16'h7C00));
        send_vec(b, 0);
        collect(0);
    endtask

    task automatic test_mid_reset();
        vec_t v = '{16'h3800, 16'h3C00, 16'h4000, 16'h4200};
        send_elem(16'h4200);
        send_elem(16'h4000);
        in_valid = 1'b0;
        test_reset();
        sb_q.push_back(mk(3, 16'h4200));
        send_vec(v, 0);
        collect(0);
    endtask

    task automatic test_nan();
        vec_t a = '{16'h3C00, 16'h7E00, 16'h4000, 16'h3800};
        vec_t b = '{16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00};
`ifdef ARGMAX_NAN_SKIP_EN
        sb_q.push_back(mk(2, 16'h4000));
`else
        sb_q.push_back(mk(1, 16'h7E00));
`endif
        send_vec(a, 0);
        collect(0);
        sb_q.push_back(mk(0, 16'h7E00));
        send_vec(b, 0);
        collect(0);
    endtask

    task automatic test_random();
        logic [15:0] pool [12] = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h0001,
                                   16'h8001, 16'h7C00, 16'hFC00, 16'h7E00, 16'hFE00,
                                   16'h4000, 16'hC000};
        vec_t v;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1) == 0) v[i] = pool[$urandom_range(11)];
                else v[i] = 16'($urandom());
            end
            sb_q.push_back(model(v));
            send_vec(v, int'($urandom_range(1)));
            collect(int'($urandom_range(2)));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ties();
        test_zero_sign();
        test_bubbles_backpressure();
        test_mid_reset();
        test_nan();
        test_random();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover size=%0d exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
